// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared FSM state encoding and FIFO depth for the BRAM stream reader
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
  localparam logic [2:0] FIFO_DEPTH = 3'd2;
endpackage

// File: rtl/bram_stream_reader_skid_fifo2.sv
// skid_fifo2: 2-entry data+last FIFO; ports clk/rst, flush, push/push_data/push_last, pop, head_data/head_last, count
module skid_fifo2
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [1:0]            count
);
  logic [DATA_WIDTH:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= {push_last, push_data};
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign {head_last, head_data} = mem[rp];
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: bursts words from a 1-cycle-latency BRAM onto a valid/ready stream; ports clk/rst, start/abort/base_addr/length, rd_addr/rd_data, m_valid/m_ready/m_data/m_last, busy/done
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0] remaining;
  logic inflight, inflight_last, head_last, pop, issue, last_issue, accept, done_pulse;
  logic [1:0] count;
  assign pop        = m_valid & m_ready;
  // Reserve a FIFO slot for every word still in the BRAM pipeline so pushes never overflow.
  assign issue      = state == RUN && remaining != '0 &&
                      ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < FIFO_DEPTH;
  assign last_issue = issue && remaining == (ADDR_WIDTH+1)'(1);
  assign accept     = state == IDLE && start;
  assign done_pulse = state != IDLE && pop && m_last;
  assign rd_addr    = addr;
  assign m_valid    = count != 2'd0;
  assign m_last     = head_last & m_valid;
  assign busy       = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = abort                          ? IDLE  :
               accept && length != '0         ? RUN   :
               state == RUN && last_issue     ? DRAIN :
               done_pulse                     ? IDLE  : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= !abort && ((accept && length == '0) || done_pulse);
      inflight      <= issue && !abort;
      inflight_last <= last_issue;
      if (abort) begin
        remaining <= '0;
      end else if (accept) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end
  skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (inflight),
    .push_data (rd_data),
    .push_last (inflight_last),
    .pop       (pop),
    .head_data (m_data),
    .head_last (head_last),
    .count     (count)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: table, hand-written and random bursts checked against a queue-based stream model
module tb_bram_stream_reader;
  localparam int AW = 8;
  localparam int DW = 12;
  logic clk = 1'b0;
  logic rst, start, abort, m_ready, m_valid, m_last, busy, done;
  logic [AW-1:0] base_addr, rd_addr;
  logic [AW:0] length;
  logic [DW-1:0] rd_data, m_data;
  always #5 clk = ~clk;
  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .length(length), .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );
  logic [DW-1:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_addr];
  typedef struct { logic [DW-1:0] d; logic l; } word_t;
  typedef struct { logic [7:0] base; logic [8:0] len; int mode; logic [DW-1:0] first; logic [DW-1:0] fin; } vec_t;
  word_t exp_q[$];
  word_t w;
  vec_t tbl[7];
  int n_cmp = 0, n_err = 0, cyc = 0, mode = 0, pops = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, done_base = 0;
  logic [DW-1:0] first_w, final_w, prev_d;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_kill = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ready patterns: 0 always, 1 the 1,0,0,1 cadence, 2 random, otherwise held low
  always @(posedge clk) begin
    #1;
    m_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) :
              mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && !abort && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 32'(m_data), 32'hFFFF_FFFF);
      else begin
        w = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(w.d));
        chk("m_last", 32'(m_last), 32'(w.l));
        if (pops == 0) first_w = m_data;
        if (m_last) begin
          final_w = m_data;
          last_pop_cyc = cyc;
        end
        pops++;
      end
    end
    if (!rst && !prev_kill && prev_v && !prev_r) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'({m_data, m_last}), 32'({prev_d, prev_l}));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_v = m_valid;
    prev_r = m_ready;
    prev_d = m_data;
    prev_l = m_last;
    prev_kill = rst | abort;
  end

  task automatic begin_burst(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk) #1;
    start = 1'b1;
    base_addr = b;
    length = l;
    pops = 0;
    done_base = done_cnt;
    for (int i = 0; i < int'(l); i++) exp_q.push_back('{mem[(int'(b) + i) % 256], i == int'(l) - 1});
    @(posedge clk) #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(l != 0));
    if (l == 0) chk("done_len0", 32'(done), 32'd1);
    @(posedge clk) #1;
    chk("valid_e1", 32'(m_valid), 32'd0);
    if (l == 0) begin
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("busy_len0", 32'(busy), 32'd0);
    end
    @(posedge clk) #1;
    chk("valid_e2", 32'(m_valid), 32'(l != 0));
  endtask

  task automatic finish_burst(input logic [8:0] l, input logic [DW-1:0] ef, input logic [DW-1:0] efin);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(posedge clk) #1;
      k++;
    end
    chk("burst_timeout", 32'(k < 3000), 32'd1);
    @(posedge clk) #1;
    chk("done_count", 32'(done_cnt - done_base), 32'd1);
    if (l != 0) begin
      chk("done_timing", 32'(done_cyc), 32'(last_pop_cyc + 1));
      chk("first_word", 32'(first_w), 32'(ef));
      chk("final_word", 32'(final_w), 32'(efin));
      chk("word_count", 32'(pops), 32'(l));
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [8:0] rl;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = DW'(12'h100 + i);
    tbl[0] = '{8'h10, 9'd4,   0, 12'h110, 12'h113};
    tbl[1] = '{8'hFE, 9'd4,   0, 12'h1FE, 12'h101};
    tbl[2] = '{8'h20, 9'd8,   1, 12'h120, 12'h127};
    tbl[3] = '{8'h00, 9'd0,   0, 12'h000, 12'h000};
    tbl[4] = '{8'h80, 9'd256, 0, 12'h180, 12'h17F};
    tbl[5] = '{8'hFF, 9'd1,   2, 12'h1FF, 12'h1FF};
    tbl[6] = '{8'h05, 9'd3,   1, 12'h105, 12'h107};
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk) #1;
    chk("idle_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode;
      begin_burst(tbl[i].base, tbl[i].len);
      finish_burst(tbl[i].len, tbl[i].first, tbl[i].fin);
    end
    mode = 0;
    begin_burst(8'h30, 9'd6);
    start = 1'b1; base_addr = 8'h90; length = 9'd3;
    @(posedge clk) #1;
    start = 1'b0;
    finish_burst(9'd6, 12'h130, 12'h135);
    begin_burst(8'h00, 9'd10);
    k = 0;
    while (pops < 3 && k < 100) begin
      @(posedge clk) #1;
      k++;
    end
    chk("abort_wait", 32'(k < 100), 32'd1);
    abort = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    done_base = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    chk("abort_quiet", 32'(m_valid), 32'd0);
    begin_burst(8'h00, 9'd2);
    finish_burst(9'd2, 12'h100, 12'h101);
    mode = 2;
    repeat (25) begin
      rb = 8'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 24));
      begin_burst(rb, rl);
      finish_burst(rl, mem[rb], mem[8'(rb + 8'(rl) - 8'd1)]);
    end
    mode = 4;
    begin_burst(8'h40, 9'd20);
    repeat (3) @(posedge clk);
    #1;
    chk("full_valid", 32'(m_valid), 32'd1);
    chk("full_data", 32'(m_data), 32'h140);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_last", 32'(m_last), 32'd0);
    chk("arst_data", 32'(m_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_addr", 32'(rd_addr), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    exp_q.delete();
    mode = 0;
    done_base = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done_cnt - done_base), 32'd0);
    begin_burst(8'h10, 9'd4);
    finish_burst(9'd4, 12'h110, 12'h113);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, BRAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the current burst.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first word address; sampled with start.
REQ-008 SHALL have port length  input  ADDR_WIDTH+1  words to read, 0..2^ADDR_WIDTH; sampled with start.
REQ-009 SHALL have port rd_addr  output  ADDR_WIDTH  BRAM read address.
REQ-010 SHALL have port rd_data  input  DATA_WIDTH  BRAM registered read data; valid one cycle after rd_addr.
REQ-011 SHALL have port m_valid  output  1  stream word available.
REQ-012 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-014 SHALL have port m_last  output  1  marks the final word of a burst.
REQ-015 SHALL have port busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a burst completes normally.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-018 IDLE: start=1 with length>0 SHALL load addr=base_addr and remaining=length, then enter RUN; start=1 with length=0 SHALL pulse done next cycle and stay in IDLE.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 A read SHALL be issued in a cycle when in RUN, remaining>0, and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
REQ-021 On issue, rd_addr SHALL present the current address; addr SHALL increment modulo 2^ADDR_WIDTH (wrap 2^ADDR_WIDTH-1 -> 0); remaining SHALL decrement.
REQ-022 The word for an issued read SHALL be captured from rd_data exactly one cycle after issue into a 2-entry FIFO; the inflight flag SHALL mark that pending capture.
REQ-023 RUN SHALL move to DRAIN when the last read is issued; DRAIN SHALL move to IDLE on the pop of the word with m_last=1, with done=1 in that same transition cycle's next edge (one-cycle pulse).
REQ-024 m_valid SHALL equal (fifo_count != 0); m_data and m_last SHALL come from the FIFO head and hold stable while m_valid=1 and m_ready=0.
REQ-025 m_last SHALL be 1 only on the word of the burst with index length-1.
REQ-026 With m_ready held high, throughput SHALL be one word per cycle; first m_valid SHALL occur 2 cycles after the start cycle.
REQ-027 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged; the FIFO SHALL never overflow or underflow.
REQ-028 abort=1 in any state SHALL return to IDLE on the next edge, flush the FIFO, discard inflight data, and not pulse done; abort has priority over start.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, rd_addr=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, fifo_count=0, inflight=0.
REQ-030 Reset mid-burst SHALL drop all buffered words; no output SHALL appear until a new start.

Structure
REQ-031 FSM state encodings (IDLE=0, RUN=1, DRAIN=2) SHALL be defined in the shared ram package; widths SHALL derive from ADDR_WIDTH/DATA_WIDTH.
REQ-032 The 2-entry FIFO SHALL be a sub-module named skid_fifo2 (push, pop, data+last, count).
REQ-033 The block SHALL connect directly to sdp_1clk_bram rd_addr/rd_data with no extra registering.

Verification
REQ-034 BRAM preloaded mem[i]=i+0x100, base=0x10, length=4, m_ready=1 -> m_data 0x110,0x111,0x112,0x113 in consecutive cycles, m_last on 0x113, done one cycle later.
REQ-035 base=0xFE, length=4 -> addresses FE,FF,00,01 read; m_data 0x1FE,0x1FF,0x100,0x101.
REQ-036 length=8, m_ready toggling 1,0,0,1 pattern -> all 8 words in order, none duplicated or lost, m_data stable while stalled.
REQ-037 length=0 -> done pulse next cycle, m_valid never asserted, busy stays 0.
REQ-038 abort asserted after 3 words popped of length=10 -> IDLE next cycle, m_valid=0, no done; new start base=0, length=2 -> 0x100,0x101.
REQ-039 rst asserted mid-burst with FIFO full -> all outputs 0 immediately; a second start while busy is ignored.
